disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display built around a single MC14495-style hex decoder. It holds a multi-digit value plus per-digit point/blank flags, and drives the decoder inputs (D3..D0, LE, point) and one active-low anode line per digit in rotation. New display data is double-buffered and committed only at frame boundaries, so no partially updated frame is ever shown.

## Interface
- DIGITS, 4: number of digits scanned (≥2)
- SCAN_DIV, 17: prescaler width; each digit slot lasts 2^SCAN_DIV cycles
- DEAD, 64: anode-off cycles at the start of each slot (< 2^SCAN_DIV)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  single-cycle strobe; captures hex_in/point_in/blank_in into pending buffer
- hex_in  in  4*DIGITS  nibble i = digit i (digit 0 = least significant, rightmost)
- point_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit forced dark
- lz_en  in  1  leading-zero suppression enable (live, not buffered)
- D  out  4  nibble to decoder D3..D0
- LE  out  1  to decoder LE; 0 = blank (decoder forces all segments off)
- point  out  1  to decoder point input
- AN  out  DIGITS  anode enables, active-low, at most one bit low
- frame_done  out  1  one-cycle pulse on the last cycle of each frame
- pend  out  1  pending buffer holds data not yet committed

## Operation
- Prescaler cnt (SCAN_DIV bits) increments every cycle and wraps; tick = (cnt == all-ones).
- Digit index idx (0..DIGITS-1) advances on tick, wraps DIGITS-1 → 0.
- Frame boundary = tick with idx == DIGITS-1; frame_done = 1 exactly in that cycle.
- Pending buffer: on load, capture hex_in/point_in/blank_in and set pend.
- Commit: at frame boundary, if pend, copy pending → active and clear pend.
- load in the commit cycle: the old pending value is committed; the new data lands in pending, and pend stays 1 for the next frame.
- Display of slot idx: D = active nibble idx; point = active point[idx].
- Blanking: LE = 0 when blank[idx], or when lz_en and idx ≥ 1 and active nibbles idx..DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
- Dead time: while cnt < DEAD, AN = all ones. Otherwise AN[idx] = 0 and all other bits are 1.
- Outputs are combinational functions of registered state plus lz_en only. There is no path from load/hex_in to the outputs.

## Timing
- Reset values: cnt = 0, idx = 0, active = 0, pending = 0, pend = 0. Outputs under reset: AN all ones, D = 0, LE = 1, point = 0, frame_done = 0.
- Reset deasserted mid-slot or mid-frame restarts from slot 0 with cnt = 0. All buffered data is lost.
- pend rises the cycle after load. Data is visible no earlier than the first slot after the next frame boundary.
- Worst-case load-to-display latency: DIGITS·2^SCAN_DIV cycles plus 1.
- idx changes in the cycle after tick. AN goes all-high in the same cycle as the idx change, because cnt wraps to 0 < DEAD.
- The frame period is exactly DIGITS·2^SCAN_DIV cycles with no jitter.

## Structure
- Shared package disp_pkg: defaults for DIGITS/SCAN_DIV/DEAD and a nibble-extract helper function.
- Sub-module scan_timer: prescaler plus digit index. Outputs cnt, idx, tick, frame_done.
- Top-level board wrapper (separate) instantiates disp_scan_ctrl and the decoder.

## Test plan
Use DIGITS=4, SCAN_DIV=3, DEAD=2 for all scenarios.
- Reset, then free run:
  - AN cycles 1110→1101→1011→0111 with an 8-cycle slot; AN = 1111 for the first 2 cycles of each slot.
  - frame_done pulses every 32 cycles.
- Update at a frame boundary:
  - load hex_in=16'h12AF mid-frame → pend = 1 and D remains 0 until the boundary.
  - The next frame shows F, A, 2, 1 on slots 0..3, and pend returns to 0.
- Double load and boundary collision:
  - load 16'h1111, then load 16'h2222 before the boundary → only 2222 is ever displayed.
  - load in the exact frame_done cycle → the previous pending value is committed and pend stays 1.
- Leading-zero suppression: active 16'h0050, lz_en = 1 → LE = 0 on slots 3 and 2, LE = 1 on slots 1 and 0. With lz_en = 0, all four slots have LE = 1.
- Point and blank flags:
  - point_in = 4'b0100 → point = 1 only in slot 2.
  - blank_in = 4'b0001 → LE = 0 in slot 0. AN still sequences normally.
- Reset mid-operation: assert rst_n = 0 during slot 2 → outputs reach reset values immediately (asynchronously), and the display restarts from slot 0 showing 0.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared defaults and helpers for the seven-segment scan
//             controller.
//  Revision : 1.0  initial release
// ============================================================================
package disp_pkg;

  // Default geometry and timing of the scanned display
  localparam int DEF_DIGITS   = 4;
  localparam int DEF_SCAN_DIV = 17;
  localparam int DEF_DEAD     = 64;

  // Widest display the nibble helper can address
  localparam int MAX_DIGITS   = 16;

  // Return nibble i of a packed hex vector (nibble 0 = least significant)
  function automatic logic [3:0] getNibble(input logic [4*MAX_DIGITS-1:0] v,
                                           input logic [31:0] i);
    return v[4*i +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Slot prescaler plus digit index for the display scanner.
//             Each slot lasts 2^SCAN_DIV cycles; a frame is DIGITS slots.
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 17,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [SCAN_DIV-1:0] cnt,
  output logic [IDX_W-1:0]    idx,
  output logic                tick,
  output logic                frameDone
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV-1:0] r_cnt;
  logic [IDX_W-1:0]    r_idx;

  // Free-running prescaler; the digit index steps once per full wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (tick) begin
        r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign tick      = &r_cnt;
  assign frameDone = tick && (r_idx == C_LAST_IDX);
  assign cnt       = r_cnt;
  assign idx       = r_idx;

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-anode
//             seven-segment display driven through one hex decoder.
//             Display data is double-buffered and swapped only at frame
//             boundaries so a frame never mixes old and new digits.
//  Revision : 1.0  initial release
// ============================================================================
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEAD     = DEF_DEAD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   point_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lz_en,
  output logic [3:0]          D,
  output logic                LE,
  output logic                point,
  output logic [DIGITS-1:0]   AN,
  output logic                frame_done,
  output logic                pend
);

  localparam int                IDX_W  = $clog2(DIGITS);
  localparam logic [SCAN_DIV-1:0] C_DEAD = SCAN_DIV'(DEAD);

  logic [SCAN_DIV-1:0] w_cnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_tick;
  logic                w_frameDone;
  logic                w_commit;

  logic [4*DIGITS-1:0] r_pendHex,   r_activeHex;
  logic [DIGITS-1:0]   r_pendPoint, r_activePoint;
  logic [DIGITS-1:0]   r_pendBlank, r_activeBlank;
  logic                r_pend;

  logic [4*MAX_DIGITS-1:0] w_hexExt;
  logic [DIGITS-1:0]       w_zeroFrom;
  logic                    w_dead;

  scan_timer #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .IDX_W    (IDX_W)
  ) u_scanTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (w_cnt),
    .idx       (w_idx),
    .tick      (w_tick),
    .frameDone (w_frameDone)
  );

  // Frame boundary: last tick of the last slot
  assign w_commit = w_tick & w_frameDone;

  // Pending buffer capture and frame-boundary commit; a load landing on the
  // boundary still commits the older pending data and stays pending itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pendHex     <= '0;
      r_pendPoint   <= '0;
      r_pendBlank   <= '0;
      r_activeHex   <= '0;
      r_activePoint <= '0;
      r_activeBlank <= '0;
      r_pend        <= 1'b0;
    end else begin
      if (w_commit && r_pend) begin
        r_activeHex   <= r_pendHex;
        r_activePoint <= r_pendPoint;
        r_activeBlank <= r_pendBlank;
      end
      if (load) begin
        r_pendHex   <= hex_in;
        r_pendPoint <= point_in;
        r_pendBlank <= blank_in;
        r_pend      <= 1'b1;
      end else if (w_commit) begin
        r_pend      <= 1'b0;
      end
    end
  end

  // zeroFrom[g] is set when digit g and every more significant digit are 0
  for (genvar g = 0; g < DIGITS; g++) begin : g_zeroFrom
    assign w_zeroFrom[g] = ~|r_activeHex[4*DIGITS-1:4*g];
  end

  // Decoder and anode drive for the current slot
  always_comb begin
    w_hexExt                 = '0;
    w_hexExt[4*DIGITS-1:0]   = r_activeHex;
    D                        = getNibble(w_hexExt, 32'(w_idx));
    point                    = r_activePoint[w_idx];
    LE                       = 1'b1;
    if (r_activeBlank[w_idx]) begin
      LE = 1'b0;
    end else if (lz_en && (w_idx != '0) && w_zeroFrom[w_idx]) begin
      LE = 1'b0;
    end
    w_dead = (w_cnt < C_DEAD);
    AN     = '1;
    if (!w_dead) begin
      AN[w_idx] = 1'b0;
    end
  end

  assign frame_done = w_frameDone;
  assign pend       = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_scan_ctrl
//  Purpose  : Self-checking bench for disp_scan_ctrl (DIGITS=4, SCAN_DIV=3,
//             DEAD=2) against a cycle-count based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_disp_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 3;
  localparam int DEAD     = 2;
  localparam int SLOT     = 1 << SCAN_DIV;
  localparam int FRAME    = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  blank_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  D;
  logic        LE;
  logic        point;
  logic [3:0]  AN;
  logic        frame_done;
  logic        pend;

  int errors = 0;
  int checks = 0;

  // Reference model: t counts cycles since reset release (equals prescaler
  // position across the whole frame), plus the two data buffers.
  int          t = 0;
  logic [15:0] mPendHex = '0, mActHex = '0;
  logic [3:0]  mPendPt  = '0, mActPt  = '0;
  logic [3:0]  mPendBl  = '0, mActBl  = '0;
  logic        mPend    = 1'b0;

  disp_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DEAD     (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hex_in     (hex_in),
    .point_in   (point_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .D          (D),
    .LE         (LE),
    .point      (point),
    .AN         (AN),
    .frame_done (frame_done),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic modelReset();
    t = 0;
    mPendHex = '0; mActHex = '0;
    mPendPt  = '0; mActPt  = '0;
    mPendBl  = '0; mActBl  = '0;
    mPend    = 1'b0;
  endtask

  // Compare every output against what the model predicts for cycle t
  task automatic checkOutputs();
    int          slot;
    int          ph;
    logic [3:0]  expAN;
    logic [3:0]  expD;
    logic        expLE;
    logic [15:0] upper;
    slot  = (t / SLOT) % DIGITS;
    ph    = t % SLOT;
    expAN = (ph < DEAD) ? 4'hF : (4'hF & ~(4'b0001 << slot));
    upper = mActHex >> (4 * slot);
    expD  = upper[3:0];
    expLE = 1'b1;
    if (mActBl[slot]) expLE = 1'b0;
    else if (lz_en && slot >= 1 && upper == 16'h0) expLE = 1'b0;
    chk("AN",         32'(AN),         32'(expAN));
    chk("D",          32'(D),          32'(expD));
    chk("LE",         32'(LE),         32'(expLE));
    chk("point",      32'(point),      32'(mActPt[slot]));
    chk("frame_done", 32'(frame_done), 32'((t % FRAME) == FRAME - 1));
    chk("pend",       32'(pend),       32'(mPend));
  endtask

  // One clock: advance model with the inputs seen at the edge, then check
  task automatic step();
    logic boundary;
    @(posedge clk);
    boundary = ((t % FRAME) == FRAME - 1);
    if (boundary && mPend) begin
      mActHex = mPendHex; mActPt = mPendPt; mActBl = mPendBl;
    end
    if (load) begin
      mPendHex = hex_in; mPendPt = point_in; mPendBl = blank_in;
      mPend    = 1'b1;
    end else if (boundary) begin
      mPend    = 1'b0;
    end
    t++;
    #1;
    checkOutputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic doLoad(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
    hex_in = h; point_in = p; blank_in = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic checkResetValues();
    chk("rst_AN",    32'(AN),         32'hF);
    chk("rst_D",     32'(D),          32'h0);
    chk("rst_LE",    32'(LE),         32'h1);
    chk("rst_point", 32'(point),      32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
    chk("rst_pend",  32'(pend),       32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    modelReset();
    rst_n = 1'b1;

    // Free run: anode rotation, dead time and frame pulse
    run(2 * FRAME);

    // Mid-frame load becomes visible only after the next boundary
    run(5);
    doLoad(16'h12AF, 4'h0, 4'h0);
    run(FRAME + 10);

    // Double load before boundary: only the second value is shown
    doLoad(16'h1111, 4'h0, 4'h0);
    run(3);
    doLoad(16'h2222, 4'h0, 4'h0);
    run(FRAME + 10);

    // Load exactly in the frame_done cycle
    doLoad(16'h3333, 4'h0, 4'h0);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != FRAME - 1; i++) step();
    doLoad(16'h4444, 4'h0, 4'h0);
    run(2 * FRAME);

    // Leading-zero suppression on and off
    lz_en = 1'b1;
    doLoad(16'h0050, 4'h0, 4'h0);
    run(2 * FRAME);
    lz_en = 1'b0;
    run(FRAME);

    // Point and blank flags
    doLoad(16'h789A, 4'b0100, 4'b0001);
    run(2 * FRAME);

    // Random loads and lz_en changes
    for (int i = 0; i < 640; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        hex_in   = 16'($urandom);
        point_in = 4'($urandom);
        blank_in = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
        if ($urandom_range(0, 1) == 1) hex_in = hex_in & 16'h00FF;
        load = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      step();
      load = 1'b0;
    end
    lz_en = 1'b0;

    // Asynchronous reset in the middle of slot 2
    doLoad(16'hBEEF, 4'hF, 4'h0);
    run(FRAME);
    for (int i = 0; i < 2 * FRAME && (t / SLOT) % DIGITS != 2; i++) step();
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues();
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutputs();
    run(FRAME + 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
